// File: rtl/modbus_req_rx.sv
// rtl/modbus_req_rx.sv - Modbus RTU slave request receiver: t1.5/t3.5 framing, address, length and CRC-16 checks
module modbus_req_rx #(
  parameter int          CLK_FREQ  = 50000000,
  parameter int          BAUD_RATE = 9600,
  parameter logic [7:0]  SADDR     = 8'h01,
  parameter int          MAX_LEN   = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rx_byte_valid,
  input  logic [7:0]  rx_byte,
  output logic        rx_busy,
  output logic        frame_valid,
  output logic [7:0]  func_code,
  output logic [15:0] start_addr,
  output logic [15:0] word_data,
  output logic        frame_err,
  output logic [1:0]  err_code
);

  localparam int          BIT_CLKS  = CLK_FREQ / BAUD_RATE;
  localparam int          T15       = BIT_CLKS * 165 / 10;
  localparam int          T35       = BIT_CLKS * 385 / 10;
  localparam logic [23:0] T15_C     = 24'(T15);
  localparam logic [23:0] T35_C     = 24'(T35);
  localparam logic [7:0]  MAX_LEN_C = 8'(MAX_LEN);
  localparam int          IDXW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_RECV  = 3'd2;
  localparam logic [2:0] ST_GAP   = 3'd3;
  localparam logic [2:0] ST_CHECK = 3'd4;

  logic [2:0]  state;
  logic [23:0] silence;
  logic [7:0]  count;
  logic [15:0] crc;
  logic        gap_bad;
  logic [7:0]  frame_buf [MAX_LEN];

  // CRC-16/Modbus, reflected polynomial, one whole byte per call
  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    end
    return r;
  endfunction

  assign rx_busy = (state == ST_RECV) || (state == ST_GAP);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state       <= ST_INIT;
      silence     <= 24'd0;
      count       <= 8'd0;
      crc         <= 16'hFFFF;
      gap_bad     <= 1'b0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= 2'd0;
      func_code   <= 8'd0;
      start_addr  <= 16'd0;
      word_data   <= 16'd0;
      for (int i = 0; i < MAX_LEN; i++) begin
        frame_buf[i] <= 8'd0;
      end
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;

      if (rx_byte_valid) begin
        silence <= 24'd0;
      end else if (silence != 24'hFFFFFF) begin
        silence <= silence + 24'd1;
      end

      case (state)
        ST_INIT: begin
          if (silence >= T35_C) begin
            state <= ST_IDLE;
          end
        end

        ST_IDLE, ST_CHECK: begin
          if (rx_byte_valid) begin
            frame_buf[0] <= rx_byte;
            count        <= 8'd1;
            crc          <= crc_upd(16'hFFFF, rx_byte);
            gap_bad      <= 1'b0;
            state        <= ST_RECV;
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_RECV, ST_GAP: begin
          if (rx_byte_valid) begin
            if (count < MAX_LEN_C) begin
              frame_buf[count[IDXW-1:0]] <= rx_byte;
            end
            if (count != 8'hFF) begin
              count <= count + 8'd1;
            end
            crc <= crc_upd(crc, rx_byte);
            if (state == ST_GAP) begin
              gap_bad <= 1'b1;
            end
          end else if (state == ST_RECV) begin
            if (silence >= T15_C) begin
              state <= ST_GAP;
            end
          end else if (silence >= T35_C) begin
            // Verdict is registered on entry to CHECK so the pulse and fields appear together
            state <= ST_CHECK;
            if (frame_buf[0] == SADDR) begin
              if (count != 8'd8) begin
                frame_err <= 1'b1;
                err_code  <= 2'd2;
              end else if (gap_bad) begin
                frame_err <= 1'b1;
                err_code  <= 2'd3;
              end else if (crc != 16'h0000) begin
                frame_err <= 1'b1;
                err_code  <= 2'd1;
              end else begin
                frame_valid <= 1'b1;
                func_code   <= frame_buf[1];
                start_addr  <= {frame_buf[2], frame_buf[3]};
                word_data   <= {frame_buf[4], frame_buf[5]};
              end
            end
          end
        end

        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_modbus_req_rx.sv
// tb/tb_modbus_req_rx.sv - directed bench for modbus_req_rx with scaled-down bit timing
module tb_modbus_req_rx;

  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 100;
  localparam int T35      = 385;
  localparam int BYTE_PER = 110;
  localparam int BUDGET   = T35 + 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_byte_valid = 1'b0;
  logic [7:0]  rx_byte = 8'd0;
  logic        rx_busy;
  logic        frame_valid;
  logic [7:0]  func_code;
  logic [15:0] start_addr;
  logic [15:0] word_data;
  logic        frame_err;
  logic [1:0]  err_code;

  int n_checks = 0;
  int n_pass   = 0;
  int fv_cnt   = 0;
  int fe_cnt   = 0;
  int both_cnt = 0;
  logic busy_seen = 1'b0;
  logic [7:0] fr [10];

  modbus_req_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD),
    .SADDR     (8'h01),
    .MAX_LEN   (8)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .rx_byte_valid (rx_byte_valid),
    .rx_byte       (rx_byte),
    .rx_busy       (rx_busy),
    .frame_valid   (frame_valid),
    .func_code     (func_code),
    .start_addr    (start_addr),
    .word_data     (word_data),
    .frame_err     (frame_err),
    .err_code      (err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid) fv_cnt++;
    if (frame_err) fe_cnt++;
    if (frame_valid && frame_err) both_cnt++;
    if (rx_busy) busy_seen = 1'b1;
  end

  task automatic load(input logic [63:0] v);
    for (int i = 0; i < 8; i++) fr[i] = v[63-8*i -: 8];
    fr[8] = 8'h00;
    fr[9] = 8'h00;
  endtask

  task automatic send_byte(input logic [7:0] b, input int idle);
    rx_byte = b;
    rx_byte_valid = 1'b1;
    @(negedge clk);
    rx_byte_valid = 1'b0;
    repeat (idle) @(negedge clk);
  endtask

  task automatic send_frame(input int n, input int pause_at, input int pause_len);
    for (int i = 0; i < n; i++) begin
      send_byte(fr[i], (i == n - 1) ? 0 : (BYTE_PER - 1 + ((i == pause_at) ? pause_len : 0)));
    end
  endtask

  task automatic wait_result(output int kind, output int k);
    kind = 0;
    k = 0;
    while (k < BUDGET && kind == 0) begin
      @(negedge clk);
      k++;
      if (frame_valid) kind = 1;
      else if (frame_err) kind = 2;
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (rx_busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", rx_busy);
    else n_pass++;
    n_checks++;
    if ({frame_valid, frame_err, err_code} !== 4'b0000)
      $display("FAIL reset_pulses got=%b exp=0000", {frame_valid, frame_err, err_code});
    else n_pass++;
    n_checks++;
    if ({func_code, start_addr, word_data} !== 40'd0)
      $display("FAIL reset_fields got=%h exp=0", {func_code, start_addr, word_data});
    else n_pass++;
    rst = 1'b0;
    repeat (T35 + 20) @(negedge clk);
  endtask

  task automatic test_read;
    int kind, k, fv0, fe0;
    fv0 = fv_cnt;
    fe0 = fe_cnt;
    load(64'h0103_0000_000A_C5CD);
    send_frame(8, -1, 0);
    wait_result(kind, k);
    n_checks++;
    if (kind !== 1) $display("FAIL read_kind got=%0d exp=1", kind); else n_pass++;
    n_checks++;
    if (k !== T35 + 1) $display("FAIL read_latency got=%0d exp=%0d", k, T35 + 1); else n_pass++;
    n_checks++;
    if ({func_code, start_addr, word_data} !== 40'h03_0000_000A)
      $display("FAIL read_fields got=%h exp=030000000a", {func_code, start_addr, word_data});
    else n_pass++;
    n_checks++;
    if (fv_cnt - fv0 !== 1) $display("FAIL read_pulse_count got=%0d exp=1", fv_cnt - fv0); else n_pass++;
    n_checks++;
    if (fe_cnt - fe0 !== 0) $display("FAIL read_no_err got=%0d exp=0", fe_cnt - fe0); else n_pass++;
  endtask

  task automatic test_write;
    int kind, k;
    load(64'h0106_0001_0003_980B);
    send_frame(8, -1, 0);
    n_checks++;
    if ({func_code, start_addr, word_data} !== 40'h03_0000_000A)
      $display("FAIL write_held got=%h exp=030000000a", {func_code, start_addr, word_data});
    else n_pass++;
    wait_result(kind, k);
    n_checks++;
    if (kind !== 1) $display("FAIL write_kind got=%0d exp=1", kind); else n_pass++;
    n_checks++;
    if ({func_code, start_addr, word_data} !== 40'h06_0001_0003)
      $display("FAIL write_fields got=%h exp=0600010003", {func_code, start_addr, word_data});
    else n_pass++;
  endtask

  task automatic test_addr_mismatch;
    int kind, k;
    busy_seen = 1'b0;
    load(64'h0203_0000_000A_C5CD);
    send_frame(8, -1, 0);
    wait_result(kind, k);
    n_checks++;
    if (kind !== 0) $display("FAIL addr_kind got=%0d exp=0", kind); else n_pass++;
    n_checks++;
    if (busy_seen !== 1'b1) $display("FAIL addr_busy_seen got=%b exp=1", busy_seen); else n_pass++;
    n_checks++;
    if (rx_busy !== 1'b0) $display("FAIL addr_busy_end got=%b exp=0", rx_busy); else n_pass++;
    n_checks++;
    if ({func_code, start_addr, word_data} !== 40'h06_0001_0003)
      $display("FAIL addr_fields got=%h exp=0600010003", {func_code, start_addr, word_data});
    else n_pass++;
  endtask

  task automatic test_errors;
    int kind, k;
    load(64'h0103_0000_000A_C5CE);
    send_frame(8, -1, 0);
    wait_result(kind, k);
    n_checks++;
    if (kind !== 2 || err_code !== 2'd1) $display("FAIL crc_err got=%0d/%0d exp=2/1", kind, err_code); else n_pass++;
    n_checks++;
    if (func_code !== 8'h06) $display("FAIL crc_fields_held got=%h exp=06", func_code); else n_pass++;
    load(64'h0103_0000_000A_C5CD);
    send_frame(7, -1, 0);
    wait_result(kind, k);
    n_checks++;
    if (kind !== 2 || err_code !== 2'd2) $display("FAIL short_err got=%0d/%0d exp=2/2", kind, err_code); else n_pass++;
    send_frame(9, -1, 0);
    wait_result(kind, k);
    n_checks++;
    if (kind !== 2 || err_code !== 2'd2) $display("FAIL long_err got=%0d/%0d exp=2/2", kind, err_code); else n_pass++;
    send_frame(8, 3, 250);
    wait_result(kind, k);
    n_checks++;
    if (kind !== 2 || err_code !== 2'd3) $display("FAIL gap_err got=%0d/%0d exp=2/3", kind, err_code); else n_pass++;
  endtask

  task automatic test_reset_midframe;
    int kind, k;
    load(64'h0103_0000_000A_C5CD);
    send_frame(3, -1, 0);
    repeat (20) @(negedge clk);
    n_checks++;
    if (rx_busy !== 1'b1) $display("FAIL mid_busy got=%b exp=1", rx_busy); else n_pass++;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (rx_busy !== 1'b0 || err_code !== 2'd0)
      $display("FAIL mid_reset_state got=%b/%0d exp=0/0", rx_busy, err_code);
    else n_pass++;
    send_frame(8, -1, 0);
    wait_result(kind, k);
    n_checks++;
    if (kind !== 0) $display("FAIL init_ignore got=%0d exp=0", kind); else n_pass++;
    send_frame(8, -1, 0);
    wait_result(kind, k);
    n_checks++;
    if (kind !== 1) $display("FAIL after_init_kind got=%0d exp=1", kind); else n_pass++;
    n_checks++;
    if ({func_code, start_addr, word_data} !== 40'h03_0000_000A)
      $display("FAIL after_init_fields got=%h exp=030000000a", {func_code, start_addr, word_data});
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_read;
    test_write;
    test_addr_mismatch;
    test_errors;
    test_reset_midframe;
    n_checks++;
    if (both_cnt !== 0) $display("FAIL both_pulses got=%0d exp=0", both_cnt); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
